// File: rtl/idex_stage.sv
// ID/EX boundary stage: 2-entry FIFO between decode and the ALU.
// Buffered register operands are kept current by snooping the writeback port,
// and the head entry is presented as ALU-ready operands.
module idex_stage #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [RAW-1:0]  in_rs1,
    input  logic [RAW-1:0]  in_rs2,
    input  logic [RAW-1:0]  in_rd,
    input  logic            in_rd_wen,
    input  logic            in_a_sel,
    input  logic            in_b_sel,
    input  logic [2:0]      in_ctrl,
    input  logic            wb_wen,
    input  logic [RAW-1:0]  wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [2:0]      out_ctrl,
    output logic [RAW-1:0]  out_rd,
    output logic            out_rd_wen,
    output logic [XLEN-1:0] out_pc
);

    // Entry storage, indexed by the 1-bit FIFO pointers.
    logic [XLEN-1:0] pc_q   [2];
    logic [XLEN-1:0] rs1v_q [2];
    logic [XLEN-1:0] rs2v_q [2];
    logic [XLEN-1:0] imm_q  [2];
    logic [RAW-1:0]  rs1_q  [2];
    logic [RAW-1:0]  rs2_q  [2];
    logic [RAW-1:0]  rd_q   [2];
    logic            rd_wen_q [2];
    logic            a_sel_q  [2];
    logic            b_sel_q  [2];
    logic [2:0]      ctrl_q   [2];

    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    logic            push;
    logic            pop;
    logic            wb_hit;
    logic [XLEN-1:0] cap_rs1;
    logic [XLEN-1:0] cap_rs2;
    logic [1:0]      hold;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready depends only on the occupancy register, never on
    // out_ready, so an upstream stall cannot form a combinational loop. flush
    // kills both transfers in its cycle even when valid and ready are high.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // Writeback to x0 is never forwarded or snooped.
    assign wb_hit  = wb_wen & (wb_rd != '0);
    assign cap_rs1 = (wb_hit && wb_rd == in_rs1) ? wb_data : in_rs1_data;
    assign cap_rs2 = (wb_hit && wb_rd == in_rs2) ? wb_data : in_rs2_data;

    // Mark entries that are occupied and survive this edge (not being popped).
    always_comb begin
        hold = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if ((count == 2'd2) || (count == 2'd1 && rd_ptr == 1'(i))) begin
                hold[i] = !(pop && rd_ptr == 1'(i));
            end
        end
    end

    // Occupancy and pointer update; flush empties the FIFO and wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (flush) begin
            count  <= 2'd0;
            rd_ptr <= wr_ptr;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            if (push && !pop)      count <= count + 2'd1;
            else if (pop && !push) count <= count - 2'd1;
        end
    end

    // Entry write on push, plus writeback snoop into held entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                pc_q[i]     <= '0;
                rs1v_q[i]   <= '0;
                rs2v_q[i]   <= '0;
                imm_q[i]    <= '0;
                rs1_q[i]    <= '0;
                rs2_q[i]    <= '0;
                rd_q[i]     <= '0;
                rd_wen_q[i] <= 1'b0;
                a_sel_q[i]  <= 1'b0;
                b_sel_q[i]  <= 1'b0;
                ctrl_q[i]   <= 3'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (hold[i] && wb_hit) begin
                    if (wb_rd == rs1_q[i]) rs1v_q[i] <= wb_data;
                    if (wb_rd == rs2_q[i]) rs2v_q[i] <= wb_data;
                end
            end
            // The push slot is never a held entry, so this cannot collide with the snoop.
            if (push) begin
                pc_q[wr_ptr]     <= in_pc;
                rs1v_q[wr_ptr]   <= cap_rs1;
                rs2v_q[wr_ptr]   <= cap_rs2;
                imm_q[wr_ptr]    <= in_imm;
                rs1_q[wr_ptr]    <= in_rs1;
                rs2_q[wr_ptr]    <= in_rs2;
                rd_q[wr_ptr]     <= in_rd;
                rd_wen_q[wr_ptr] <= in_rd_wen;
                a_sel_q[wr_ptr]  <= in_a_sel;
                b_sel_q[wr_ptr]  <= in_b_sel;
                ctrl_q[wr_ptr]   <= in_ctrl;
            end
        end
    end

    // ALU operand selection from the head entry.
    assign out_a      = a_sel_q[rd_ptr] ? pc_q[rd_ptr]  : rs1v_q[rd_ptr];
    assign out_b      = b_sel_q[rd_ptr] ? imm_q[rd_ptr] : rs2v_q[rd_ptr];
    assign out_ctrl   = ctrl_q[rd_ptr];
    assign out_rd     = rd_q[rd_ptr];
    assign out_rd_wen = rd_wen_q[rd_ptr];
    assign out_pc     = pc_q[rd_ptr];

endmodule
